// File: rtl/binary_4bit_subtractor_pkg.sv
// binary_4bit_subtractor_pkg: shared width constant and operand type for the small arithmetic leaf blocks
package binary_4bit_subtractor_pkg;

    localparam int SUB_WIDTH = 4;

    typedef logic [SUB_WIDTH-1:0] sub_operand_t;

endpackage

// File: rtl/binary_4bit_subtractor_full_adder.sv
// sub_full_adder: single-bit full adder cell used as one stage of the ripple chain
module sub_full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/binary_4bit_subtractor.sv
// binary_4bit_subtractor: registered s = a - b via a ripple of full adders on a and ~b with carry-in 1
// Optional OVERFLOW_FLAG_EN adds a registered signed-overflow output ovf.
module binary_4bit_subtractor
    import binary_4bit_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             co,
    output logic [WIDTH-1:0] s
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             co_q;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        sub_full_adder u_fa (
            .x   (a[i]),
            .y   (~b[i]),
            .cin (c[i]),
            .sum (s_d[i]),
            .cout(c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            co_q <= c[WIDTH];
        end
    end

    assign s  = s_q;
    assign co = co_q;

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;

    // signed overflow: carries into and out of the sign stage disagree
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= c[WIDTH] ^ c[WIDTH-1];
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_binary_4bit_subtractor.sv
// tb_binary_4bit_subtractor: arithmetic reference model checked every cycle plus directed literal vectors
module tb_binary_4bit_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = 4'hF;
    logic [3:0] b = 4'h0;
    logic       co;
    logic [3:0] s;
`ifdef OVERFLOW_FLAG_EN
    logic       ovf;
    logic       exp_ovf;
`endif
    logic [3:0] exp_s;
    logic       exp_co;
    logic       valid = 1'b0;
    int         total = 0;
    int         bad = 0;

    binary_4bit_subtractor dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
`ifdef OVERFLOW_FLAG_EN
        .ovf(ovf),
`endif
        .co (co),
        .s  (s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (a=%0d b=%0d)", n, act, req, a, b);
        end
    endtask

    // reference: plain integer subtraction, unsigned compare, signed range test
    always @(posedge clk) begin
        int d;
        d = int'($signed(a)) - int'($signed(b));
        valid  <= 1'b1;
        exp_s  <= rst ? 4'd0 : 4'((int'(a) - int'(b) + 16) % 16);
        exp_co <= rst ? 1'b0 : (int'(a) >= int'(b));
`ifdef OVERFLOW_FLAG_EN
        exp_ovf <= rst ? 1'b0 : (d > 7 || d < -8);
`endif
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("model_s", int'(s), int'(exp_s));
            chk("model_co", int'(co), int'(exp_co));
`ifdef OVERFLOW_FLAG_EN
            chk("model_ovf", int'(ovf), int'(exp_ovf));
`endif
        end
    end

    task automatic step(input logic r, input logic [3:0] va, input logic [3:0] vb);
        rst = r;
        a = va;
        b = vb;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] va [7] = '{4'h1, 4'h5, 4'hD, 4'h9, 4'h3, 4'hF, 4'h1};
    logic [3:0] vb [7] = '{4'h3, 4'hB, 4'h3, 4'h3, 4'h3, 4'hD, 4'hB};
    logic [3:0] vs [7] = '{4'hE, 4'hA, 4'hA, 4'h6, 4'h0, 4'h2, 4'h6};
    logic       vc [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        step(1'b1, 4'hF, 4'h0);
        chk("rst1_s", int'(s), 0);
        chk("rst1_co", int'(co), 0);
        step(1'b1, 4'hF, 4'h0);
        chk("rst2_s", int'(s), 0);
        chk("rst2_co", int'(co), 0);
        step(1'b0, 4'h0, 4'h0);
        chk("zero_s", int'(s), 0);
        chk("zero_co", int'(co), 1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, va[i], vb[i]);
            chk("vec_s", int'(s), int'(vs[i]));
            chk("vec_co", int'(co), int'(vc[i]));
        end
        step(1'b1, 4'h7, 4'h2);
        chk("midrst_s", int'(s), 0);
        chk("midrst_co", int'(co), 0);
        step(1'b0, 4'h8, 4'h3);
        chk("release_s", int'(s), 5);
        chk("release_co", int'(co), 1);
`ifdef OVERFLOW_FLAG_EN
        step(1'b0, 4'h7, 4'h8);
        chk("ovf1_s", int'(s), 15);
        chk("ovf1_ovf", int'(ovf), 1);
        step(1'b0, 4'h5, 4'h3);
        chk("ovf0_s", int'(s), 2);
        chk("ovf0_ovf", int'(ovf), 0);
`endif
        for (int i = 0; i < 256; i++) step(1'b0, 4'(i >> 4), 4'(i));
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
